// File: rtl/vga_timing_recovery.sv
// Receive-side VGA timing recovery. Measures line and frame geometry from the incoming syncs,
// locks on stable timing, and recovers pixel coordinates plus data-enable two cycles after the pins.
module vga_timing_recovery #(
    parameter int H_ACTIVE    = 640,
    parameter int H_START     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int V_START     = 35,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync_n,
    input  logic          vsync_n,
    input  logic [3:0]    r_in,
    input  logic [3:0]    g_in,
    input  logic [3:0]    b_in,
    output logic [9:0]    px,
    output logic [9:0]    py,
    output logic          de,
    output logic [3:0]    r,
    output logic [3:0]    g,
    output logic [3:0]    b,
    output logic          frame_start,
    output logic          locked,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] H_LO    = CW'(H_START);
    localparam logic [CW-1:0] H_HI    = CW'(H_START + H_ACTIVE);
    localparam logic [CW-1:0] V_LO    = CW'(V_START);
    localparam logic [CW-1:0] V_HI    = CW'(V_START + V_ACTIVE);
    localparam int            MW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_FRAMES);
    localparam logic [MW-1:0] ONE     = MW'(1);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

    state_t        state, state_next;
    logic          hs_q, vs_q, hs_prev, vs_prev;
    logic [3:0]    r_q, g_q, b_q;
    logic [CW-1:0] h_cnt, v_cnt, h_now, v_now, h_meas, v_meas;
    logic [CW-1:0] h_ref, v_ref, h_ref_next, v_ref_next;
    logic [MW-1:0] match_cnt, match_next, match_inc;
    logic          href_ok, href_next;
    logic          vs_pend, h_seen, v_seen;
    logic          line_start, vs_fall, frame_edge, sat_hit, in_active, de_next;

    // Input sample stage; edges are taken against the previous registered sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            hs_q    <= hsync_n;
            vs_q    <= vsync_n;
            hs_prev <= hs_q;
            vs_prev <= vs_q;
            r_q     <= r_in;
            g_q     <= g_in;
            b_q     <= b_in;
        end
    end

    assign line_start = hs_prev & ~hs_q;
    assign vs_fall    = vs_prev & ~vs_q;
    assign frame_edge = line_start & (vs_fall | vs_pend);

    // h_now/v_now are the counts belonging to the sample currently in the input stage.
    assign h_meas    = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + CW'(1);
    assign v_meas    = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + CW'(1);
    assign h_now     = line_start ? '0 : h_meas;
    assign v_now     = frame_edge ? '0 : (line_start ? v_meas : v_cnt);
    assign sat_hit   = (h_now == CNT_MAX) || (v_now == CNT_MAX);
    assign in_active = (h_now >= H_LO) && (h_now < H_HI) && (v_now >= V_LO) && (v_now < V_HI);
    assign match_inc = match_cnt + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            vs_pend <= 1'b0;
            h_seen  <= 1'b0;
            v_seen  <= 1'b0;
        end else begin
            h_cnt   <= h_now;
            v_cnt   <= v_now;
            vs_pend <= frame_edge ? 1'b0 : (vs_fall ? 1'b1 : vs_pend);
            // A saturated counter means the current line/frame is partial, so skip its measurement.
            h_seen  <= sat_hit ? 1'b0 : (line_start ? 1'b1 : h_seen);
            v_seen  <= sat_hit ? 1'b0 : (frame_edge ? 1'b1 : v_seen);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        h_ref_next = h_ref;
        v_ref_next = v_ref;
        match_next = match_cnt;
        href_next  = href_ok;
        case (state)
            SEARCH: begin
                if (frame_edge) begin
                    state_next = MEASURE;
                    href_next  = 1'b0;
                end
            end
            MEASURE: begin
                if (line_start) begin
                    if (!href_ok) begin
                        h_ref_next = h_meas;
                        href_next  = 1'b1;
                    end else if (h_meas != h_ref) begin
                        state_next = SEARCH;
                    end
                end
                if (frame_edge && state_next == MEASURE) begin
                    v_ref_next = v_meas;
                    match_next = ONE;
                    state_next = (LOCK_FRAMES <= 1) ? LOCKED : CHECK;
                end
            end
            CHECK, LOCKED: begin
                if (line_start && h_meas != h_ref) begin
                    state_next = SEARCH;
                end else if (frame_edge) begin
                    if (v_meas != v_ref) begin
                        state_next = SEARCH;
                    end else if (state == CHECK) begin
                        match_next = match_inc;
                        if (match_inc >= LOCK_N) state_next = LOCKED;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
        if (state != SEARCH && sat_hit) state_next = SEARCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            h_ref     <= '0;
            v_ref     <= '0;
            match_cnt <= '0;
            href_ok   <= 1'b0;
        end else begin
            state     <= state_next;
            h_ref     <= h_ref_next;
            v_ref     <= v_ref_next;
            match_cnt <= match_next;
            href_ok   <= href_next;
        end
    end

    // Output stage: lock and de follow the post-update state, so a mismatch blanks its own sample.
    assign de_next = (state_next == LOCKED) && in_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            px          <= '0;
            py          <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            h_total     <= '0;
            v_total     <= '0;
        end else begin
            de          <= de_next;
            locked      <= (state_next == LOCKED);
            frame_start <= frame_edge && (state_next != SEARCH);
            r           <= de_next ? r_q : 4'd0;
            g           <= de_next ? g_q : 4'd0;
            b           <= de_next ? b_q : 4'd0;
            if (de_next) begin
                px <= 10'(h_now - H_LO);
                py <= 10'(v_now - V_LO);
            end
            if (line_start && h_seen) h_total <= h_meas;
            if (frame_edge && v_seen) v_total <= v_meas;
        end
    end

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Directed bench for vga_timing_recovery on a scaled-down raster; expected outputs are queued
// per driven sample and compared two cycles later.
module tb_vga_timing_recovery;

    localparam int HA = 16, HS_ST = 6, VA = 8, VS_ST = 3, LF = 2, CW = 8;
    localparam int HT = 30, HSW = 4, VT = 14, VSW = 2;
    localparam int LOSE = 300, RST_C = 10, PIX = HA * VA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hsync_n = 1'b1, vsync_n = 1'b1;
    logic [3:0]    r_in = '0, g_in = '0, b_in = '0;
    logic [9:0]    px, py;
    logic          de, frame_start, locked;
    logic [3:0]    r, g, b;
    logic [CW-1:0] h_total, v_total;

    always #5 clk = ~clk;

    vga_timing_recovery #(
        .H_ACTIVE(HA), .H_START(HS_ST), .V_ACTIVE(VA), .V_START(VS_ST),
        .LOCK_FRAMES(LF), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .px(px), .py(py), .de(de), .r(r), .g(g), .b(b),
        .frame_start(frame_start), .locked(locked),
        .h_total(h_total), .v_total(v_total)
    );

    typedef struct packed {
        logic       de;
        logic [9:0] px;
        logic [9:0] py;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       fs;
        logic       lk;
    } obs_t;

    obs_t       sb[$];
    int         checks = 0, errors = 0;
    bit         exp_lock = 1'b0, rst_release = 1'b0;
    logic [9:0] last_px = '0, last_py = '0;
    int         de_cnt = 0;
    logic [9:0] seen_px = '0, seen_py = '0, first_px = '0, first_py = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_de"}, 64'(de), 0);
        check_val({tag, "_px"}, 64'(px), 0);
        check_val({tag, "_py"}, 64'(py), 0);
        check_val({tag, "_rgb"}, 64'({r, g, b}), 0);
        check_val({tag, "_frame_start"}, 64'(frame_start), 0);
        check_val({tag, "_locked"}, 64'(locked), 0);
        check_val({tag, "_h_total"}, 64'(h_total), 0);
        check_val({tag, "_v_total"}, 64'(v_total), 0);
    endtask

    // One input cycle: compare the output due from two samples ago, then drive and queue this one.
    task automatic step(input logic hs, input logic vs, input bit valid,
                        input int x, input int y, input bit fs);
        obs_t       got, exp_o, e;
        logic [9:0] xv, yv;
        logic [3:0] rr, gg, bb;
        @(negedge clk);
        if (sb.size() >= 2) begin
            exp_o = sb.pop_front();
            got   = {de, px, py, r, g, b, frame_start, locked};
            checks++;
            assert (got === exp_o) else begin
                errors++;
                $error("FAIL pixel_out t=%0t: observed de=%b px=%0d py=%0d rgb=%h%h%h fs=%b lk=%b expected de=%b px=%0d py=%0d rgb=%h%h%h fs=%b lk=%b",
                       $time, got.de, got.px, got.py, got.r, got.g, got.b, got.fs, got.lk,
                       exp_o.de, exp_o.px, exp_o.py, exp_o.r, exp_o.g, exp_o.b, exp_o.fs, exp_o.lk);
            end
            if (de === 1'b1) begin
                if (de_cnt == 0) begin
                    first_px = px;
                    first_py = py;
                end
                de_cnt++;
                seen_px = px;
                seen_py = py;
            end
        end
        xv = 10'(x);
        yv = 10'(y);
        if (valid) begin
            rr = xv[3:0];
            gg = yv[3:0];
            bb = xv[7:4];
        end else begin
            rr = 4'($urandom_range(0, 15));
            gg = 4'($urandom_range(0, 15));
            bb = 4'($urandom_range(0, 15));
        end
        hsync_n = hs;
        vsync_n = vs;
        r_in    = rr;
        g_in    = gg;
        b_in    = bb;
        e.de = exp_lock && valid;
        if (e.de) begin
            last_px = xv;
            last_py = yv;
        end
        e.px = last_px;
        e.py = last_py;
        e.r  = e.de ? rr : 4'd0;
        e.g  = e.de ? gg : 4'd0;
        e.b  = e.de ? bb : 4'd0;
        e.fs = fs;
        e.lk = exp_lock;
        sb.push_back(e);
        if (rst_release) begin
            #1 rst = 1'b0;
            rst_release = 1'b0;
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 check_zero("async_reset");
        sb.delete();
        exp_lock    = 1'b0;
        last_px     = '0;
        last_py     = '0;
        rst_release = 1'b1;
    endtask

    // One frame: vsync and hsync fall together on line 0. Optional disturbances by line number.
    task automatic drive_frame(input bit lk, input int stretch_line, input int lose_line,
                               input int reset_line);
        int  len;
        bit  valid;
        exp_lock = lk;
        de_cnt   = 0;
        for (int l = 0; l < VT; l++) begin
            if (l == lose_line) begin
                for (int k = 1; k <= LOSE; k++) begin
                    if (k >= (1 << CW) - HT) exp_lock = 1'b0;
                    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
                end
                return;
            end
            len = (l == stretch_line) ? HT + 1 : HT;
            for (int c = 0; c < len; c++) begin
                if (stretch_line >= 0 && l == stretch_line + 1 && c == 0) exp_lock = 1'b0;
                if (l == reset_line && c == RST_C) do_reset();
                valid = (c >= HS_ST) && (c < HS_ST + HA) && (l >= VS_ST) && (l < VS_ST + VA);
                step(c >= HSW, l >= VSW, valid, c - HS_ST, l - VS_ST, (l == 0) && (c == 0));
            end
        end
    endtask

    task automatic check_clean_frame(input string tag);
        check_val({tag, "_de_count"}, 64'(de_cnt), PIX);
        check_val({tag, "_last_px"}, 64'(seen_px), HA - 1);
        check_val({tag, "_last_py"}, 64'(seen_py), VA - 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset_idle");
        repeat (5) @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b0;
        repeat (40) step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);

        // Nominal acquisition: MEASURE, CHECK, then locked from the third frame start.
        drive_frame(1'b0, -1, -1, -1);
        check_val("h_total_after_f1", 64'(h_total), HT);
        check_val("v_total_after_f1", 64'(v_total), 0);
        drive_frame(1'b0, -1, -1, -1);
        check_val("v_total_after_f2", 64'(v_total), VT);
        drive_frame(1'b1, -1, -1, -1);
        check_clean_frame("first_locked");
        check_val("first_de_px", 64'(first_px), 0);
        check_val("first_de_py", 64'(first_py), 0);
        drive_frame(1'b1, -1, -1, -1);
        check_clean_frame("sweep");

        // One stretched line while locked, then reacquire.
        drive_frame(1'b1, 5, -1, -1);
        check_val("stretch_de_count", 64'(de_cnt), 3 * HA);
        check_val("stretch_h_total", 64'(h_total), HT);
        drive_frame(1'b0, -1, -1, -1);
        drive_frame(1'b0, -1, -1, -1);
        drive_frame(1'b1, -1, -1, -1);
        check_clean_frame("relock_stretch");

        // Hsync lost long enough to saturate h_cnt.
        drive_frame(1'b1, -1, 5, -1);
        check_val("lose_de_count", 64'(de_cnt), 2 * HA);
        check_val("lose_locked", 64'(locked), 0);
        check_val("lose_h_total", 64'(h_total), HT);
        drive_frame(1'b0, -1, -1, -1);
        drive_frame(1'b0, -1, -1, -1);
        drive_frame(1'b1, -1, -1, -1);
        check_clean_frame("relock_lose");
        check_val("relock_lose_v_total", 64'(v_total), VT);

        // Asynchronous reset pulse mid-frame while locked.
        drive_frame(1'b1, -1, -1, 6);
        check_val("reset_frame_de_count", 64'(de_cnt), 3 * HA + 2);
        drive_frame(1'b0, -1, -1, -1);
        drive_frame(1'b0, -1, -1, -1);
        drive_frame(1'b1, -1, -1, -1);
        check_clean_frame("relock_reset");
        check_val("relock_reset_h_total", 64'(h_total), HT);
        check_val("relock_reset_v_total", 64'(v_total), VT);

        repeat (4) step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
